// File: rtl/ram_arbiter_if.sv
// Bundle of requester handshakes and RAM-side bus signals for ram_arbiter.
// slave: the arbiter's view; master: the clients and RAM environment around it.
interface ram_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
);
    logic                  req0;
    logic                  req1;
    logic                  we0;
    logic                  we1;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] wdata0;
    logic [DATA_WIDTH-1:0] wdata1;
    logic                  done0;
    logic                  done1;
    logic [DATA_WIDTH-1:0] rdata0;
    logic [DATA_WIDTH-1:0] rdata1;
    logic                  busy;
    logic                  ram_cs;
    logic                  ram_w_r1;
    logic                  ram_oe;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic                  ram_wdata_en;
    logic [DATA_WIDTH-1:0] ram_rdata;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_rdata,
        output done0, done1, rdata0, rdata1, busy,
               ram_cs, ram_w_r1, ram_oe, ram_addr, ram_wdata, ram_wdata_en
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_rdata,
        input  done0, done1, rdata0, rdata1, busy,
               ram_cs, ram_w_r1, ram_oe, ram_addr, ram_wdata, ram_wdata_en
    );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter between two requesters for a single-port synchronous RAM.
// Sequences a 1-cycle write or a 2-cycle read (latch, then output-enable), then a
// DONE cycle that pulses the requester's done and gives the data bus a turnaround.
//
// state   | meaning
// IDLE    | sample req0/req1, grant one, register its access
// WR      | cs, w_r1 and the write driver active for one cycle
// RD_ADDR | cs with w_r1=0; RAM latches mem[addr]
// RD_DATA | cs and oe; RAM drives the bus, captured at the closing edge
// DONE    | all RAM controls low, done pulse to the granted requester
//
// Outputs are registered: the output logic decodes the *next* state so that the
// registered controls line up with the state they belong to.
module ram_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    ram_arbiter_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, WR, RD_ADDR, RD_DATA, DONE} state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  ptr;
    logic                  gnt_id;
    logic                  gnt_we;
    logic [ADDR_WIDTH-1:0] gnt_addr;
    logic [DATA_WIDTH-1:0] gnt_wdata;

    logic                  grant0;
    logic                  grant1;
    logic                  any_req;
    logic                  sel_id;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    logic                  cs_nxt;
    logic                  w_r1_nxt;
    logic                  oe_nxt;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic [DATA_WIDTH-1:0] wdata_nxt;
    logic                  wdata_en_nxt;
    logic                  done0_nxt;
    logic                  done1_nxt;
    logic                  busy_nxt;

    // Grant selection: in IDLE the live request mux, otherwise the registered grant.
    always_comb begin
        grant0  = bus.req0 & (~bus.req1 | ~ptr);
        grant1  = bus.req1 & ~grant0;
        any_req = bus.req0 | bus.req1;
        if (state == IDLE) begin
            sel_id    = grant1;
            sel_we    = grant1 ? bus.we1    : bus.we0;
            sel_addr  = grant1 ? bus.addr1  : bus.addr0;
            sel_wdata = grant1 ? bus.wdata1 : bus.wdata0;
        end else begin
            sel_id    = gnt_id;
            sel_we    = gnt_we;
            sel_addr  = gnt_addr;
            sel_wdata = gnt_wdata;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = sel_we ? WR : RD_ADDR;
            WR:      state_nxt = DONE;
            RD_ADDR: state_nxt = RD_DATA;
            RD_DATA: state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode for the state being entered; registered below.
    always_comb begin
        cs_nxt       = 1'b0;
        w_r1_nxt     = 1'b0;
        oe_nxt       = 1'b0;
        addr_nxt     = '0;
        wdata_nxt    = '0;
        wdata_en_nxt = 1'b0;
        done0_nxt    = 1'b0;
        done1_nxt    = 1'b0;
        busy_nxt     = (state_nxt != IDLE);
        case (state_nxt)
            WR: begin
                cs_nxt       = 1'b1;
                w_r1_nxt     = 1'b1;
                addr_nxt     = sel_addr;
                wdata_nxt    = sel_wdata;
                wdata_en_nxt = 1'b1;
            end
            RD_ADDR: begin
                cs_nxt   = 1'b1;
                addr_nxt = sel_addr;
            end
            RD_DATA: begin
                cs_nxt   = 1'b1;
                oe_nxt   = 1'b1;
                addr_nxt = sel_addr;
            end
            DONE: begin
                done0_nxt = ~sel_id;
                done1_nxt = sel_id;
            end
            default: ;
        endcase
    end

    // State, grant registers, registered outputs and read-data capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            ptr              <= 1'b0;
            gnt_id           <= 1'b0;
            gnt_we           <= 1'b0;
            gnt_addr         <= '0;
            gnt_wdata        <= '0;
            bus.ram_cs       <= 1'b0;
            bus.ram_w_r1     <= 1'b0;
            bus.ram_oe       <= 1'b0;
            bus.ram_addr     <= '0;
            bus.ram_wdata    <= '0;
            bus.ram_wdata_en <= 1'b0;
            bus.done0        <= 1'b0;
            bus.done1        <= 1'b0;
            bus.busy         <= 1'b0;
            bus.rdata0       <= '0;
            bus.rdata1       <= '0;
        end else begin
            state            <= state_nxt;
            bus.ram_cs       <= cs_nxt;
            bus.ram_w_r1     <= w_r1_nxt;
            bus.ram_oe       <= oe_nxt;
            bus.ram_addr     <= addr_nxt;
            bus.ram_wdata    <= wdata_nxt;
            bus.ram_wdata_en <= wdata_en_nxt;
            bus.done0        <= done0_nxt;
            bus.done1        <= done1_nxt;
            bus.busy         <= busy_nxt;
            if (state == IDLE && any_req) begin
                ptr       <= ~sel_id;
                gnt_id    <= sel_id;
                gnt_we    <= sel_we;
                gnt_addr  <= sel_addr;
                gnt_wdata <= sel_wdata;
            end
            if (state == RD_DATA) begin
                if (gnt_id) bus.rdata1 <= bus.ram_rdata;
                else        bus.rdata0 <= bus.ram_rdata;
            end
        end
    end
endmodule
